// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package imem_pkg;
  localparam int INST_W = 32;
  localparam int PC_W   = 32;
  localparam logic [INST_W-1:0] NOP_INST      = 32'h0;
  localparam logic [PC_W-1:0]   RESET_PC_DFLT = 32'h0000_0000;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } fetch_entry_t;
endpackage

// File: rtl/imem_fifo.sv
// Synchronous FIFO of fetch entries with flush; head is read combinationally
// from registered storage.
module imem_fifo
  import imem_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_dat_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o
);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && (count_q != '0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // The upstream credit scheme must never let a word arrive at a full FIFO.
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    do_push |-> (count_q != FULL_C));
endmodule

// File: rtl/imem_prefetch.sv
// Fetch front end: owns the fetch PC, issues credit-limited ROM reads through a
// ROM_LAT-deep in-flight pipe and buffers returned words for decode.
module imem_prefetch
  import imem_pkg::*;
#(
  parameter int              ADDR_W   = 10,
  parameter int              DEPTH    = 4,
  parameter int              ROM_LAT  = 1,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_i,
  input  logic [PC_W-1:0]   redirect_pc_i,
  input  logic              inst_ready_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [PC_W-1:0]   inst_pc_o,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_data_i
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [ROM_LAT-1:0] infl_vld_q, infl_vld_d;
  logic [PC_W-1:0]    infl_pc_q [ROM_LAT];
  logic [PC_W-1:0]    infl_pc_d [ROM_LAT];
  logic [CW-1:0]      occ, infl_cnt;
  logic               issue;
  fetch_entry_t       push_dat, head;
  logic               unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc_i[1:0];

  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < ROM_LAT; i++) infl_cnt = infl_cnt + CW'(infl_vld_q[i]);
  end

  // Words already buffered plus words still in the ROM pipe count against FIFO space.
  assign issue = !rst && !redirect_i && (({1'b0, occ} + {1'b0, infl_cnt}) < DEPTH_C);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    infl_vld_d = '0;
    for (int i = 0; i < ROM_LAT; i++) infl_pc_d[i] = infl_pc_q[i];
    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[PC_W-1:2], 2'b00};
    end else begin
      infl_vld_d[0] = issue;
      infl_pc_d[0]  = fetch_pc_q;
      for (int i = 1; i < ROM_LAT; i++) begin
        infl_vld_d[i] = infl_vld_q[i-1];
        infl_pc_d[i]  = infl_pc_q[i-1];
      end
      if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      infl_vld_q <= '0;
      for (int i = 0; i < ROM_LAT; i++) infl_pc_q[i] <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      infl_vld_q <= infl_vld_d;
      for (int i = 0; i < ROM_LAT; i++) infl_pc_q[i] <= infl_pc_d[i];
    end
  end

  assign push_dat.inst = rom_data_i;
  assign push_dat.pc   = infl_pc_q[ROM_LAT-1];

  imem_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (redirect_i),
    .push_i     (infl_vld_q[ROM_LAT-1]),
    .push_dat_i (push_dat),
    .pop_i      (inst_ready_i),
    .head_o     (head),
    .count_o    (occ)
  );

  assign rom_ce_o     = issue;
  assign rom_addr_o   = issue ? fetch_pc_q[ADDR_W+1:2] : '0;
  assign inst_valid_o = (occ != '0);
  assign inst_o       = inst_valid_o ? head.inst : NOP_INST;
  assign inst_pc_o    = inst_valid_o ? head.pc : '0;
endmodule

// File: tb/tb_imem_prefetch.sv
// Randomized scoreboard bench for imem_prefetch: expected stream is the
// sequential PC walk from the last reset/redirect looked up in a ROM image.
`timescale 1ns/1ps
module tb_imem_prefetch;
  import imem_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;
  localparam int LAT    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              redirect_i = 1'b0;
  logic [31:0]       redirect_pc_i = '0;
  logic              inst_ready_i = 1'b0;
  logic              inst_valid_o;
  logic [31:0]       inst_o;
  logic [31:0]       inst_pc_o;
  logic              rom_ce_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [31:0]       rom_data_i = '0;

  int checks = 0;
  int failures = 0;
  int outstanding = 0;
  logic [31:0] rom [1 << ADDR_W];
  fetch_entry_t exp_q [$];
  logic [31:0] exp_fill_pc = '0;
  logic [31:0] exp_req_pc = '0;

  logic              rp_vld [LAT];
  logic [ADDR_W-1:0] rp_addr [LAT];
  logic              ce_s;
  logic [ADDR_W-1:0] a_s;

  imem_prefetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .ROM_LAT(LAT), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inst_ready_i  (inst_ready_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .rom_ce_o      (rom_ce_o),
    .rom_addr_o    (rom_addr_o),
    .rom_data_i    (rom_data_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refill();
    fetch_entry_t e;
    while (exp_q.size() < 64) begin
      e.pc   = exp_fill_pc;
      e.inst = rom[exp_fill_pc[ADDR_W+1:2]];
      exp_q.push_back(e);
      exp_fill_pc = exp_fill_pc + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    exp_fill_pc = {pc[31:2], 2'b00};
    exp_req_pc  = {pc[31:2], 2'b00};
    refill();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    refill();
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_i    = 1'b1;
    redirect_pc_i = pc;
    restart(pc);
    step();
    redirect_i = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, 32'(inst_valid_o), 32'h0);
    chk({tag, "_inst"},  inst_o, 32'h0);
    chk({tag, "_pc"},    inst_pc_o, 32'h0);
    chk({tag, "_ce"},    32'(rom_ce_o), 32'h0);
    chk({tag, "_addr"},  32'(rom_addr_o), 32'h0);
  endtask

  // ROM: returns rom[addr] LAT cycles after a sampled request, garbage otherwise.
  initial begin
    for (int i = 0; i < LAT; i++) begin
      rp_vld[i]  = 1'b0;
      rp_addr[i] = '0;
    end
    forever begin
      @(negedge clk);
      ce_s = rom_ce_o;
      a_s  = rom_addr_o;
      @(posedge clk);
      #1;
      for (int i = LAT - 1; i > 0; i--) begin
        rp_vld[i]  = rp_vld[i-1];
        rp_addr[i] = rp_addr[i-1];
      end
      rp_vld[0]  = ce_s;
      rp_addr[0] = a_s;
      rom_data_i = rp_vld[LAT-1] ? rom[rp_addr[LAT-1]] : $urandom;
    end
  end

  // Monitor: request-address sequence, delivered stream and credit bound.
  initial begin
    fetch_entry_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        outstanding = 0;
      end else if (redirect_i) begin
        chk("redirect_no_issue", 32'(rom_ce_o), 32'h0);
        outstanding = 0;
      end else begin
        if (rom_ce_o) begin
          chk("req_addr", 32'(rom_addr_o), 32'(exp_req_pc[ADDR_W+1:2]));
          exp_req_pc = exp_req_pc + 32'd4;
          outstanding++;
        end
        if (inst_valid_o && inst_ready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty: got pc 0x%08h expected none", inst_pc_o);
          end else begin
            e = exp_q.pop_front();
            chk("inst_pc", inst_pc_o, e.pc);
            chk("inst", inst_o, e.inst);
          end
          outstanding--;
        end
        checks++;
        if (outstanding > DEPTH || outstanding < 0) begin
          failures++;
          $display("FAIL credit_bound: got %0d outstanding expected 0..%0d", outstanding, DEPTH);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int hs;
    logic [31:0] held_pc;
    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = $urandom;
    restart(32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");

    rst = 1'b0;
    inst_ready_i = 1'b1;
    @(negedge clk);
    chk("cycle0_ce", 32'(rom_ce_o), 32'h1);
    chk("cycle0_addr", 32'(rom_addr_o), 32'h0);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      @(negedge clk);
      if (inst_valid_o) begin
        lat = c;
        break;
      end
    end
    chk("first_valid_cycle", 32'(lat), 32'(LAT + 1));

    hs = 0;
    repeat (20) begin
      step();
      @(negedge clk);
      if (inst_valid_o && inst_ready_i) hs++;
    end
    chk("throughput", 32'(hs), 32'd20);

    step();
    inst_ready_i = 1'b0;
    held_pc = inst_pc_o;
    chk("stall_start_valid", 32'(inst_valid_o), 32'h1);
    repeat (10) step();
    @(negedge clk);
    chk("stall_ce_off", 32'(rom_ce_o), 32'h0);
    chk("stall_pc_held", inst_pc_o, held_pc);
    chk("stall_full", 32'(outstanding), 32'(DEPTH));
    step();
    inst_ready_i = 1'b1;
    repeat (15) step();

    inst_ready_i = 1'b0;
    repeat (2) step();
    inst_ready_i = 1'b1;
    do_redirect(32'h0000_0103);
    @(negedge clk);
    chk("redir_flushed", 32'(inst_valid_o), 32'h0);
    chk("redir_first_ce", 32'(rom_ce_o), 32'h1);
    chk("redir_first_addr", 32'(rom_addr_o), 32'h40);
    lat = 0;
    for (int k = 2; k <= 20; k++) begin
      step();
      @(negedge clk);
      if (inst_valid_o) begin
        lat = k;
        break;
      end
    end
    chk("redir_latency", 32'(lat), 32'(2 + LAT));
    chk("redir_first_pc", inst_pc_o, 32'h100);
    repeat (8) step();

    do_redirect(32'hFFFF_FFF8);
    @(negedge clk);
    chk("wrap_addr0", 32'(rom_addr_o), 32'h3FE);
    step();
    @(negedge clk);
    chk("wrap_addr1", 32'(rom_addr_o), 32'h3FF);
    step();
    @(negedge clk);
    chk("wrap_addr2", 32'(rom_addr_o), 32'h000);
    repeat (12) step();

    repeat (1000) begin
      inst_ready_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0) do_redirect($urandom);
      else step();
    end

    inst_ready_i = 1'b0;
    repeat (12) step();
    @(negedge clk);
    chk("prereset_full", 32'(outstanding), 32'(DEPTH));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_zero_outputs("async_reset");
    repeat (2) step();
    restart(32'h0);
    rst = 1'b0;
    inst_ready_i = 1'b1;
    @(negedge clk);
    chk("restart_ce", 32'(rom_ce_o), 32'h1);
    chk("restart_addr", 32'(rom_addr_o), 32'h0);
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
